// File: rtl/sm_step_ctrl.sv
// sm_step_ctrl: run / halt / single-step controller for the sm_cpu core.
// It drives the core clock enable (cpu_en), so each enabled cycle retires
// one instruction. It also counts retired instructions.
// Optional PC breakpoint support is enabled by defining the macro
// SM_STEP_CTRL_BREAK_EN. The default build leaves that macro undefined:
// SETBRK is then accepted but has no effect, and brk_hit stays 0.
module sm_step_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_arg,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_en,
  output logic            halted,
  output logic            brk_hit,
  output logic            done,
  output logic [31:0]     ret_cnt
);

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEPN  = 2'b10;
  localparam logic [1:0] OP_SETBRK = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t           state_r, state_n;
  logic [CNT_W-1:0] step_cnt_r, step_cnt_n;
  logic             done_r, done_n;
  logic [31:0]      ret_cnt_r;

  logic             cmd_acc_s;
  logic             halt_cmd_s;
  logic             last_step_s;
  logic             brk_match_s;
  logic             cpu_en_s;
  logic [CNT_W-1:0] step_arg_s;
  logic             unused_s;

`ifdef SM_STEP_CTRL_BREAK_EN
  localparam bit PC_FULL = (PC_W >= 32);

  logic            brk_valid_r, brk_valid_n;
  logic [PC_W-1:0] brk_pc_r, brk_pc_n;
  logic            skip_r, skip_n;
  logic            brk_hit_r, brk_hit_n;
  logic            brk_en_s;

  // With a full 32-bit PC there is no spare enable bit, so SETBRK always arms.
  assign brk_en_s    = PC_FULL ? 1'b1 : cmd_arg[31];
  // skip masks the breakpoint for the first executing cycle so a resume
  // from the breakpoint PC makes progress.
  assign brk_match_s = brk_valid_r && (pc == brk_pc_r) && !skip_r;
  assign brk_hit     = brk_hit_r;
`else
  assign brk_match_s = 1'b0;
  assign brk_hit     = 1'b0;
`endif

  // Argument bits not used by every configuration are folded in here.
  assign unused_s = ^{cmd_arg, pc};

  assign step_arg_s  = cmd_arg[CNT_W-1:0];
  assign cmd_ready   = (state_r == ST_HALT) || (cmd_op == OP_HALT);
  assign cmd_acc_s   = cmd_valid && cmd_ready;
  assign halt_cmd_s  = cmd_acc_s && (cmd_op == OP_HALT);
  assign cpu_en_s    = (state_r != ST_HALT) && !brk_match_s;
  assign last_step_s = (state_r == ST_STEP) && cpu_en_s && (step_cnt_r == CNT_ONE);

  assign cpu_en  = cpu_en_s;
  assign halted  = (state_r == ST_HALT);
  assign done    = done_r;
  assign ret_cnt = ret_cnt_r;

  // Next-state and next-register computation for the run/step FSM.
  always_comb begin
    state_n    = state_r;
    step_cnt_n = step_cnt_r;
    done_n     = 1'b0;
`ifdef SM_STEP_CTRL_BREAK_EN
    brk_valid_n = brk_valid_r;
    brk_pc_n    = brk_pc_r;
    skip_n      = skip_r;
    brk_hit_n   = brk_hit_r;
`endif
    case (state_r)
      ST_HALT: begin
        if (cmd_acc_s) begin
          case (cmd_op)
            OP_RUN: begin
              state_n = ST_RUN;
`ifdef SM_STEP_CTRL_BREAK_EN
              skip_n    = 1'b1;
              brk_hit_n = 1'b0;
`endif
            end
            OP_STEPN: begin
`ifdef SM_STEP_CTRL_BREAK_EN
              brk_hit_n = 1'b0;
`endif
              if (step_arg_s != CNT_ZERO) begin
                state_n    = ST_STEP;
                step_cnt_n = step_arg_s;
`ifdef SM_STEP_CTRL_BREAK_EN
                skip_n = 1'b1;
`endif
              end else begin
                // Zero-length step: nothing executes, but the host still
                // sees a completion pulse.
                done_n = 1'b1;
              end
            end
            OP_SETBRK: begin
`ifdef SM_STEP_CTRL_BREAK_EN
              brk_valid_n = brk_en_s;
              brk_pc_n    = cmd_arg[PC_W-1:0];
`endif
            end
            default: begin
              // HALT while halted is a no-op.
              state_n = ST_HALT;
            end
          endcase
        end else begin
          state_n = ST_HALT;
        end
      end
      ST_RUN, ST_STEP: begin
`ifdef SM_STEP_CTRL_BREAK_EN
        skip_n = 1'b0;
`endif
        if ((state_r == ST_STEP) && cpu_en_s) begin
          step_cnt_n = step_cnt_r - CNT_ONE;
        end else begin
          step_cnt_n = step_cnt_r;
        end
        // All exit causes merge into a single transition, hence a single done.
        if (brk_match_s || halt_cmd_s || last_step_s) begin
          state_n = ST_HALT;
          done_n  = 1'b1;
`ifdef SM_STEP_CTRL_BREAK_EN
          if (brk_match_s) begin
            brk_hit_n = 1'b1;
          end else begin
            brk_hit_n = brk_hit_r;
          end
`endif
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_HALT;
      end
    endcase
  end

  // State and control registers, asynchronously reset to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HALT;
      step_cnt_r <= CNT_ZERO;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      step_cnt_r <= step_cnt_n;
      done_r     <= done_n;
    end
  end

`ifdef SM_STEP_CTRL_BREAK_EN
  // Breakpoint registers; reset disarms the breakpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_valid_r <= 1'b0;
      brk_pc_r    <= {PC_W{1'b0}};
      skip_r      <= 1'b0;
      brk_hit_r   <= 1'b0;
    end else begin
      brk_valid_r <= brk_valid_n;
      brk_pc_r    <= brk_pc_n;
      skip_r      <= skip_n;
      brk_hit_r   <= brk_hit_n;
    end
  end
`endif

  // Retired-instruction counter; wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt_r <= 32'd0;
    end else if (cpu_en_s) begin
      ret_cnt_r <= ret_cnt_r + 32'd1;
    end else begin
      ret_cnt_r <= ret_cnt_r;
    end
  end

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Directed bench for sm_step_ctrl. A tiny core model advances pc on every
// enabled cycle. Breakpoint expectations depend on SM_STEP_CTRL_BREAK_EN.
module tb_sm_step_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic        brk_hit;
  logic        done;
  logic [31:0] ret_cnt;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int en_base;
  int done_base;

  sm_step_ctrl #(.CNT_W(16), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .brk_hit(brk_hit), .done(done), .ret_cnt(ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: one instruction per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd1;
  end

  // Count enabled cycles and done pulses as seen at each active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      en_cnt   <= en_cnt + (cpu_en ? 1 : 0);
      done_cnt <= done_cnt + (done ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at the current negedge; it is sampled at the next posedge.
  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 32'd0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    chk(tag, {31'd0, halted}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic mark();
    en_base   = en_cnt;
    done_base = done_cnt;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    mark();
    repeat (10) @(negedge clk);
    chk("idle_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("idle_halted", {31'd0, halted}, 32'd1);
    chk("idle_ret_cnt", ret_cnt, 32'd0);
    chk("idle_pc", pc, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_done", done_cnt - done_base, 32'd0);

    // STEPN 3.
    mark();
    send(2'b10, 32'd3);
    wait_halt("step3_halt");
    chk("step3_en", en_cnt - en_base, 32'd3);
    chk("step3_pc", pc, 32'd3);
    chk("step3_done", done_cnt - done_base, 32'd1);
    chk("step3_ret", ret_cnt, 32'd3);

    // RUN then HALT; the accepting cycle still executes.
    mark();
    send(2'b01, 32'd0);
    cmd_op = 2'b01;
    #1;
    chk("run_ready_busy", {31'd0, cmd_ready}, 32'd0);
    cmd_op = 2'b00;
    #1;
    chk("run_ready_halt", {31'd0, cmd_ready}, 32'd1);
    chk("run_halted", {31'd0, halted}, 32'd0);
    repeat (5) @(negedge clk);
    send(2'b00, 32'd0);
    wait_halt("run_halt");
    chk("run_en", en_cnt - en_base, 32'd6);
    chk("run_ret", ret_cnt, 32'd9);
    chk("run_pc", pc, 32'd9);
    chk("run_done", done_cnt - done_base, 32'd1);
    chk("run_brk_hit", {31'd0, brk_hit}, 32'd0);

    // Breakpoint at pc 4 while running from pc 0.
    do_reset();
    mark();
    send(2'b11, 32'd4);
    repeat (2) @(negedge clk);
    chk("setbrk_done", done_cnt - done_base, 32'd0);
    chk("setbrk_halted", {31'd0, halted}, 32'd1);
`ifdef SM_STEP_CTRL_BREAK_EN
    send(2'b01, 32'd0);
    wait_halt("brk_halt");
    chk("brk_pc", pc, 32'd4);
    chk("brk_ret", ret_cnt, 32'd4);
    chk("brk_hit", {31'd0, brk_hit}, 32'd1);
    chk("brk_done", done_cnt - done_base, 32'd1);
    mark();
    send(2'b10, 32'd1);
    wait_halt("skip_halt");
    chk("skip_pc", pc, 32'd5);
    chk("skip_brk_hit", {31'd0, brk_hit}, 32'd0);
    chk("skip_done", done_cnt - done_base, 32'd1);
`else
    send(2'b10, 32'd6);
    wait_halt("nobrk_halt");
    chk("nobrk_pc", pc, 32'd6);
    chk("nobrk_ret", ret_cnt, 32'd6);
    chk("nobrk_brk_hit", {31'd0, brk_hit}, 32'd0);
`endif

    // Last step lands exactly on the breakpoint PC: no hit.
    do_reset();
    send(2'b11, 32'd2);
    mark();
    send(2'b10, 32'd2);
    wait_halt("land_halt");
    chk("land_pc", pc, 32'd2);
    chk("land_brk_hit", {31'd0, brk_hit}, 32'd0);
    chk("land_done", done_cnt - done_base, 32'd1);
    chk("land_ret", ret_cnt, 32'd2);

    // STEPN 5 runs into the breakpoint at pc 2.
    do_reset();
    send(2'b11, 32'd2);
    mark();
    send(2'b10, 32'd5);
    wait_halt("s5_halt");
    chk("s5_done", done_cnt - done_base, 32'd1);
`ifdef SM_STEP_CTRL_BREAK_EN
    chk("s5_pc", pc, 32'd2);
    chk("s5_brk_hit", {31'd0, brk_hit}, 32'd1);
    chk("s5_ret", ret_cnt, 32'd2);
`else
    chk("s5_pc", pc, 32'd5);
    chk("s5_brk_hit", {31'd0, brk_hit}, 32'd0);
    chk("s5_ret", ret_cnt, 32'd5);
`endif

    // Breakpoint coincides with the last step: breakpoint wins.
    do_reset();
    send(2'b11, 32'd2);
    mark();
    send(2'b10, 32'd3);
    wait_halt("s3b_halt");
    chk("s3b_done", done_cnt - done_base, 32'd1);
`ifdef SM_STEP_CTRL_BREAK_EN
    chk("s3b_pc", pc, 32'd2);
    chk("s3b_brk_hit", {31'd0, brk_hit}, 32'd1);
`else
    chk("s3b_pc", pc, 32'd3);
    chk("s3b_brk_hit", {31'd0, brk_hit}, 32'd0);
`endif

    // STEPN 0: completion pulse, nothing executes.
    do_reset();
    mark();
    send(2'b10, 32'd0);
    repeat (3) @(negedge clk);
    chk("s0_en", en_cnt - en_base, 32'd0);
    chk("s0_done", done_cnt - done_base, 32'd1);
    chk("s0_pc", pc, 32'd0);
    chk("s0_halted", {31'd0, halted}, 32'd1);

    // Reset mid-RUN clears state and the breakpoint.
    send(2'b11, 32'd20);
    send(2'b01, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_running", {31'd0, cpu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_ret", ret_cnt, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'b01, 32'd0);
    repeat (25) @(negedge clk);
    chk("rerun_pc", pc, 32'd25);
    chk("rerun_halted", {31'd0, halted}, 32'd0);
    chk("rerun_brk_hit", {31'd0, brk_hit}, 32'd0);
    send(2'b00, 32'd0);
    wait_halt("rerun_halt");
    chk("rerun_ret", ret_cnt, 32'd26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
